// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: a single full-adder cell and a carry flip-flop process
//   the operands LSB first, one bit per clock. Operands are captured on an
//   accepted start; the result appears WIDTH clocks later with a one-cycle
//   done pulse and is held until the next completion.
//
//   Optional feature (macro SERIAL_ADDER_SUB_EN):
//     adds input 'sub'; with sub=1 the block computes a - b - cin by adding
//     ~b with carry-in ~cin, and reports the inverted final carry as borrow.
//
// Parameters
//   WIDTH   operand/result width, 2..64
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, sampled only while not busy
//   a, b    operands, captured on accepted start
//   cin     carry-in (borrow-in when sub=1)
//   sub     subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy    high while bits are being processed
//   done    one-cycle pulse, sum/cout valid
//   sum     registered result
//   cout    registered carry-out (borrow-out when sub=1)
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | one operand bit consumed per clock
    // S_DONE | result valid for one cycle; start here begins the next run

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_accept;
    logic               w_last;
    logic               w_s_bit;
    logic               w_carry_nxt;
    logic [WIDTH-1:0]   w_res_nxt;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_cin_in;
    logic               w_cout_inv;

`ifdef SERIAL_ADDER_SUB_EN
    logic               r_sub;

    assign w_b_in     = sub ? ~b : b;
    assign w_cin_in   = sub ? ~cin : cin;
    assign w_cout_inv = r_sub;
`else
    assign w_b_in     = b;
    assign w_cin_in   = cin;
    assign w_cout_inv = 1'b0;
`endif

    assign w_accept    = start && (r_state != S_RUN);
    assign w_last      = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_s_bit     = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_carry_nxt = (r_a_sh[0] & r_b_sh[0]) |
                         (r_a_sh[0] & r_carry)   |
                         (r_b_sh[0] & r_carry);
    assign w_res_nxt   = {w_s_bit, r_res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= w_b_in;
            r_res_sh <= '0;
            r_carry  <= w_cin_in;
            r_cnt    <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub    <= sub;
`endif
        end else if (r_state == S_RUN) begin
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_res_sh <= w_res_nxt;
            r_carry  <= w_carry_nxt;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_res_nxt;
                // in subtract mode the carry is an inverted borrow
                r_cout <= w_carry_nxt ^ w_cout_inv;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_chk;
    int n_bad;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // drive a request so it is accepted at the next rising edge (E0),
    // then scramble the operand inputs to prove they were captured
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tc, input logic ts);
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb;
        cin   = tc;
        sub   = ts;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~ta;
        b     = ~tb;
        cin   = ~tc;
        sub   = ~ts;
    endtask

    // observe E1..E12 after acceptance; optionally re-pulse start at E3
    task automatic run_op(input string tag,
                          input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts,
                          input logic [W-1:0] exp_sum, input logic exp_cout,
                          input bit repulse);
        start_op(ta, tb, tc, ts);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_busy"}, busy, (k < W) ? 1 : 0);
            chk({tag, "_done"}, done, (k == W) ? 1 : 0);
            if (k >= W) begin
                chk({tag, "_sum"},  sum,  exp_sum);
                chk({tag, "_cout"}, cout, exp_cout);
            end
            if (repulse && k == 2) begin
                start = 1'b1;
                a     = '0;
                b     = '0;
                cin   = 1'b0;
            end
            if (repulse && k == 3) start = 1'b0;
        end
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        sub   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum",  sum,  0);
        chk("rst_cout", cout, 0);
        rst_n = 1'b1;

        // 1: plain add, no carry
        run_op("t1", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0);
        // 2: full carry ripple with carry-in, result held afterwards
        run_op("t2", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        // 3: start re-pulsed mid-run must be ignored
        run_op("t3", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b1);

        // 4: reset in the middle of a run
        start_op(8'h55, 8'h22, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t4_busy", busy, 1);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_rbusy", busy, 0);
        chk("t4_rdone", done, 0);
        chk("t4_rsum",  sum,  0);
        chk("t4_rcout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t4_idle_done", done, 0);
            chk("t4_idle_busy", busy, 0);
        end

        // 5: back-to-back, start held during done
        start_op(8'h80, 8'h80, 1'b0, 1'b0);
        for (int k = 1; k <= W; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t5a_busy", busy, (k < W) ? 1 : 0);
            chk("t5a_done", done, (k == W) ? 1 : 0);
        end
        chk("t5a_sum",  sum,  8'h00);
        chk("t5a_cout", cout, 1);
        start = 1'b1;
        a     = 8'h0F;
        b     = 8'h01;
        cin   = 1'b0;
        sub   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'hAA;
        b     = 8'hAA;
        for (int k = 1; k <= W; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t5b_busy", busy, (k < W) ? 1 : 0);
            chk("t5b_done", done, (k == W) ? 1 : 0);
            if (k < W) chk("t5b_hold", sum, 8'h00);
        end
        chk("t5b_sum",  sum,  8'h10);
        chk("t5b_cout", cout, 0);

`ifdef SERIAL_ADDER_SUB_EN
        // 6: subtraction, with and without borrow
        run_op("t6a", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0);
        run_op("t6b", 8'h20, 8'h10, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0);
        run_op("t6c", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
